// File: rtl/btn_scan_pkg.sv
// Shared types for the push-button scan controller: scan FSM states, the
// queued event record and the channel-index width helper.
package btn_scan_pkg;

  // Event ids are sized for the largest supported bank (16 channels).
  localparam int ID_MAX_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic                level;
  } evt_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_scan_ctrl_if.sv
// Button event handshake: the controller is the master presenting the head
// event, the OLED sequencer is the slave returning ready.
interface btn_scan_ctrl_if
  import btn_scan_pkg::*;
#(
  parameter int ID_W = idx_w(5)
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_level;

  modport master (output evt_valid, evt_id, evt_level, input evt_ready);
  modport slave  (input evt_valid, evt_id, evt_level, output evt_ready);
endinterface

// File: rtl/btn_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is dropped and
// reported on ovf unless a pop frees the head slot in the same cycle.
module btn_evt_fifo
  import btn_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty,
  output logic ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end
endmodule

// File: rtl/btn_scan_ctrl.sv
// Round-robin debounce of the button bank with one shared counter engine.
// Define BTN_SCAN_RELEASE_EVT_EN to queue release events as well as presses.
module btn_scan_ctrl
  import btn_scan_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int TICK_DIV    = 1000,
  parameter int COUNT_MAX   = 15,
  parameter int COUNT_WIDTH = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  btn_scan_ctrl_if.master  evt,
  output logic             evt_ovf,
  input  logic             ovf_clr
);
  localparam int IW = idx_w(N_BTN);
  localparam int PW = $clog2(TICK_DIV);
`ifdef BTN_SCAN_RELEASE_EVT_EN
  localparam bit RELEASE_EN = 1'b1;
`else
  localparam bit RELEASE_EN = 1'b0;
`endif

  logic [N_BTN-1:0]       sync1_reg, sync2_reg, btn_state_reg;
  logic [PW-1:0]          presc_reg;
  logic                   tick;
  scan_state_t            state_reg, state_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic                   scan_en;
  logic [COUNT_WIDTH-1:0] cnt_reg [N_BTN];
  logic [COUNT_WIDTH-1:0] cnt_cur, cnt_next;
  logic                   sample, stable, flip, push;
  evt_t                   push_data, head;
  logic                   fifo_full, fifo_empty, fifo_ovf;

  assign tick = (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      presc_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      presc_reg <= tick ? '0 : presc_reg + PW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    scan_en    = 1'b0;
    case (state_reg)
      ST_IDLE: if (tick) begin
        state_next = ST_SCAN;
        idx_next   = '0;
      end
      ST_SCAN: begin
        scan_en = 1'b1;
        if (idx_reg == IW'(N_BTN - 1)) state_next = ST_IDLE;
        else                           idx_next   = idx_reg + IW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shared engine: only the channel selected by idx_reg is evaluated.
  always_comb begin
    sample   = sync2_reg[idx_reg];
    stable   = btn_state_reg[idx_reg];
    cnt_cur  = cnt_reg[idx_reg];
    cnt_next = '0;
    flip     = 1'b0;
    if (sample != stable) begin
      if (cnt_cur >= COUNT_WIDTH'(COUNT_MAX)) flip = 1'b1;
      else                                   cnt_next = cnt_cur + COUNT_WIDTH'(1);
    end
  end

  assign push      = scan_en && flip && (sample || RELEASE_EN);
  assign push_data = '{id: ID_MAX_W'(idx_reg), level: sample};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      btn_state_reg <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (scan_en) begin
        cnt_reg[idx_reg] <= cnt_next;
        if (flip) btn_state_reg[idx_reg] <= sample;
      end
    end
  end

  // A dropped event outranks a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        evt_ovf <= 1'b0;
    else if (fifo_ovf) evt_ovf <= 1'b1;
    else if (ovf_clr)  evt_ovf <= 1'b0;
  end

  btn_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (evt.evt_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf       (fifo_ovf)
  );

  assert property (@(posedge clk) disable iff (!rst_n) fifo_ovf |-> fifo_full);

  assign btn_state     = btn_state_reg;
  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_id    = fifo_empty ? '0 : IW'(head.id);
  assign evt.evt_level = !fifo_empty && head.level;
endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl: a per-sweep reference model predicts
// debounced levels and queued events; a negedge monitor checks the event port.
module tb_btn_scan_ctrl;
  import btn_scan_pkg::*;

  localparam int N  = 5;
  localparam int TD = 8;
  localparam int CM = 3;
  localparam int CW = 4;
  localparam int FD = 4;
`ifdef BTN_SCAN_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_state;
  logic         evt_ovf;
  logic         ovf_clr = 1'b0;

  btn_scan_ctrl_if #(.ID_W(idx_w(N))) evt_if ();

  btn_scan_ctrl #(
    .N_BTN(N), .TICK_DIV(TD), .COUNT_MAX(CM), .COUNT_WIDTH(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_state (btn_state),
    .evt       (evt_if),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int level;
  } exp_evt_t;

  int           n_pass = 0;
  int           n_total = 0;
  exp_evt_t     exp_q[$];
  logic [N-1:0] m_state = '0;
  int           m_run[N];
  bit           exp_ovf = 1'b0;
  int           rdy_mode = 1;
  int           rcyc = 0;
  logic [3:0]   rv;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One sweep samples every channel once; a level flips after CM+1
  // consecutive disagreeing sweeps.
  function automatic void model_sweep(input logic [N-1:0] v, input bit stall);
    for (int ch = 0; ch < N; ch++) begin
      if (v[ch] == m_state[ch]) m_run[ch] = 0;
      else begin
        m_run[ch]++;
        if (m_run[ch] == CM + 1) begin
          m_run[ch]   = 0;
          m_state[ch] = v[ch];
          if (v[ch] || REL) begin
            if (stall && exp_q.size() >= FD) exp_ovf = 1'b1;
            else exp_q.push_back('{id: ch, level: int'(v[ch])});
          end
        end
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_state = '0;
    exp_ovf = 1'b0;
    for (int ch = 0; ch < N; ch++) m_run[ch] = 0;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_btn_state"}, int'(btn_state), 0);
    chk({tag, "_evt_valid"}, int'(evt_if.evt_valid), 0);
    chk({tag, "_evt_id"}, int'(evt_if.evt_id), 0);
    chk({tag, "_evt_level"}, int'(evt_if.evt_level), 0);
    chk({tag, "_evt_ovf"}, int'(evt_ovf), 0);
  endtask

  // Called 6 clocks into the scan period: the previous sweep is complete and
  // the new raw value settles through the synchronizer before the next sweep.
  task automatic period(input logic [N-1:0] v, input bit bp = 1'b0, input bit clr = 1'b0);
    chk("btn_state", int'(btn_state), int'(m_state));
    chk("evt_ovf", int'(evt_ovf), int'(exp_ovf));
    btn_raw = v;
    ovf_clr = clr;
    if (clr) exp_ovf = 1'b0;
    model_sweep(v, (rdy_mode == 0) && !bp);
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(posedge clk); #1 if (bp) rdy_mode = 1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [N-1:0] v);
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) period(v);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rcyc++;
      case (rdy_mode)
        0:       evt_if.evt_ready = 1'b0;
        1:       evt_if.evt_ready = 1'b1;
        default: evt_if.evt_ready = (rcyc % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && evt_if.evt_valid) begin
      if (exp_q.size() == 0) chk("spurious_evt_valid", int'(evt_if.evt_valid), 0);
      else begin
        chk("evt_id", int'(evt_if.evt_id), exp_q[0].id);
        chk("evt_level", int'(evt_if.evt_level), exp_q[0].level);
        if (evt_if.evt_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk_reset("post_rst");

    // clean press on channel 2
    repeat (6) period(5'b00100);
    // channel 0 bounces, then holds together with channel 4
    for (int i = 0; i < 10; i++) period((i % 2 == 0) ? 5'b00101 : 5'b00100);
    repeat (5) period(5'b10101);
    // release channel 4
    repeat (5) period(5'b00101);

    // randomized bouncing on channels 0..3 with random backpressure
    rdy_mode = 2;
    rv = 4'b0101;
    for (int s = 0; s < 40; s++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) rv[b] = ~rv[b];
      period({1'b0, rv});
    end
    rdy_mode = 1;
    repeat (5) period(5'b00000);
    drain(5'b00000);

    // overflow: five presses into a stalled four-entry FIFO
    rdy_mode = 0;
    repeat (5) period(5'b11111);
    period(5'b11111, 1'b0, 1'b1);
    // release channel 0 while still stalled
    repeat (5) period(5'b11110);
    // press channel 0 again; ready rises exactly as the full FIFO is pushed
    repeat (3) period(5'b11111);
    period(5'b11111, 1'b1, 1'b0);
    repeat (2) period(5'b11111);
    drain(5'b11111);
    period(5'b11111, 1'b0, 1'b1);

    // reset during channel 3's scan cycle with an event pending
    repeat (5) period(5'b00000);
    drain(5'b00000);
    rdy_mode = 0;
    repeat (3) period(5'b01001);
    chk("btn_state", int'(btn_state), int'(m_state));
    btn_raw = 5'b01001;
    model_sweep(5'b01001, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("pending_before_rst", int'(evt_if.evt_valid), (exp_q.size() > 0) ? 1 : 0);
    rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    model_reset();
    btn_raw  = '0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk_reset("post_mid_rst");
    repeat (5) period(5'b00000);
    chk("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/btn_scan_ctrl.md
# btn_scan_ctrl

Time-multiplexed debounce controller for the OLED demo's push-button bank. One shared counter engine serves N_BTN raw button inputs, scanned round-robin on a prescaled tick. Edges are debounced with the same stable-for-COUNT_MAX rule used across the OLED front end. Debounced levels are published directly, and press events are queued in a small valid/ready event FIFO for the OLED control sequencer.

## Interface
- N_BTN, 5: number of button channels, 1..16
- TICK_DIV, 1000: clk cycles between scan sweeps; must be ≥ N_BTN+2
- COUNT_MAX, 15: consecutive disagreeing samples before a level flips (flip on sample COUNT_MAX+1)
- COUNT_WIDTH, 4: counter width; must hold COUNT_MAX
- FIFO_DEPTH, 4: event FIFO entries, power of two
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  N_BTN  raw, asynchronous button pins
- btn_state  out  N_BTN  debounced levels
- evt_valid  out  1  event available at FIFO head
- evt_ready  in  1  consumer accepts head event
- evt_id  out  $clog2(N_BTN) (min 1)  channel index of head event
- evt_level  out  1  new debounced level of head event (1 = press)
- evt_ovf  out  1  sticky: an event was dropped because the FIFO was full
- ovf_clr  in  1  clears evt_ovf

## Operation
- btn_raw passes through a two-flop synchronizer per bit. The synchronizer resets to 0.
- Prescaler counts 0..TICK_DIV-1 and asserts a tick at terminal count.
- Scan FSM states:
  - IDLE: waits for the tick, then sets idx=0 and moves to SCAN.
  - SCAN: one channel per clk. Reads the per-channel counter, compares the synchronized sample with btn_state[idx], and writes back. Increments idx; after idx=N_BTN-1 returns to IDLE.
- Per-channel update rule, applied in the SCAN cycle for that channel:
  - Sample equals stable: counter ← 0.
  - Sample differs and counter < COUNT_MAX: counter ← counter+1.
  - Sample differs and counter == COUNT_MAX: stable bit flips, counter ← 0, event {idx, new level} is pushed.
- Counters never exceed COUNT_MAX and do not wrap.
- At most one push per clk, because only one channel is visited per cycle.
- FIFO behaviour:
  - Push when full: event dropped, evt_ovf set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
- evt_ovf:
  - ovf_clr clears it.
  - A simultaneous overflow and ovf_clr leaves it set.

## Timing
- Reset values:
  - btn_state=0, all counters 0, FSM IDLE, prescaler 0, FIFO empty.
  - evt_valid=0, evt_id=0, evt_level=0, evt_ovf=0.
- First tick occurs TICK_DIV clks after reset release.
- Synchronizer latency is 2 clks.
- btn_state[i] changes on the clk edge that ends channel i's SCAN cycle.
- The pushed event is visible on evt_valid/evt_id/evt_level on that same edge (FIFO is first-word-fall-through).
- Debounce latency for a clean edge: the level changes on the (COUNT_MAX+1)th consecutive sweep that samples the new level.
- A single agreeing sample during the transition resets the count.
- Handshake:
  - Transfer occurs when evt_valid && evt_ready at a rising clk edge.
  - Head outputs are stable while evt_valid=1 and evt_ready=0.
- A reset assertion mid-sweep aborts the sweep immediately and forces all reset values. Pending events are lost.

## Configuration
- BTN_SCAN_RELEASE_EVT_EN:
  - Defined: both press (level 1) and release (level 0) flips push events.
  - Undefined: only press flips push events; release flips update btn_state only, and evt_level is always 1.

## Structure
- Package btn_scan_pkg holds:
  - scan FSM state enum (ST_IDLE, ST_SCAN)
  - event struct {id, level}
  - idx width function.
- Sub-module btn_evt_fifo: parameterized first-word-fall-through FIFO with valid/ready, full/empty and an overflow pulse output.
- Per-channel counters are a register array indexed by idx. There is no per-channel debouncer instance.

## Test plan
- Clean press, N_BTN=5, TICK_DIV=8, COUNT_MAX=3: hold btn_raw[2]=1 from reset. Required: btn_state[2] rises on the 4th sweep, and exactly one event {id=2, level=1} is delivered.
- Bounce: toggle btn_raw[0] 1/0 on alternate sweeps for 10 sweeps, then hold 1. Required: no event during bouncing; btn_state[0] rises on the 4th sweep after the hold begins.
- Release events: with btn_state[4]=1, drop btn_raw[4] to 0. Required with BTN_SCAN_RELEASE_EVT_EN: event {4, 0}. Required without it: no event, and btn_state[4] still falls.
- Overflow: evt_ready=0, generate 5 press events with FIFO_DEPTH=4. Required: 4 events retained in order and evt_ovf=1. Pulse ovf_clr: evt_ovf=0.
- Backpressure: full FIFO with evt_ready=1 while a new event pushes. Required: no overflow, and order is preserved.
- Reset mid-sweep: assert rst_n=0 during channel 3's SCAN cycle with a pending event. Required: all outputs return to reset values, and there is no spurious event after release.
